benes4_crossbar: RTL and testbench



---
 rtl/benes4_crossbar.sv | 160 ++++++++++++++++
 tb/tb_benes4_crossbar.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/benes4_crossbar.sv
// benes4_crossbar: registered 4x4 Benes permutation network of N-bit words.
//
// Three columns of 2x2 crossbar elements (crbar2) route x1..x4 to y1..y4
// under a 3-bit route code. Each column's elements share one select bit:
// s[2] is column 1, s[1] is column 2 and s[0] is column 3. The eight codes
// alias in pairs, which gives four distinct permutations.
//
// Build option (macro BENES4_PIPE_EN):
//   undefined - columns are combinational, one output register, latency 1.
//   defined   - register after every column, latency 3; the select bits
//               not yet consumed travel with the data.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset; clears all state
//   in_valid   x1..x4 and s are meaningful this cycle
//   x1..x4     input lanes, N bits each
//   s          route code {col1, col2, col3}
//   out_valid  y1..y4 hold a routed word set (in_valid delayed by latency)
//   y1..y4     output lanes, N bits each
module benes4_crossbar #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] x2,
  input  logic [N-1:0] x3,
  input  logic [N-1:0] x4,
  input  logic [2:0]   s,
  output logic         out_valid,
  output logic [N-1:0] y1,
  output logic [N-1:0] y2,
  output logic [N-1:0] y3,
  output logic [N-1:0] y4
);

  // 2x2 element, result packed as {p, q}: c=0 passes, c=1 crosses.
  function automatic logic [2*N-1:0] crbar2(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic         c);
    return c ? {b, a} : {a, b};
  endfunction

  // Column outputs
  logic [N-1:0] w_l0, w_l1, w_l2, w_l3;
  logic [N-1:0] w_m0, w_m1, w_m2, w_m3;
  logic [N-1:0] w_y1, w_y2, w_y3, w_y4;

  // Column 2/3 sources: either straight from the previous column or from
  // the pipeline registers behind it.
  logic [N-1:0] w_c2_a0, w_c2_a1, w_c2_a2, w_c2_a3;
  logic         w_c2_sel;
  logic [N-1:0] w_c3_a0, w_c3_a1, w_c3_a2, w_c3_a3;
  logic         w_c3_sel;
  logic         w_out_valid_d;

  // Column 1
  assign {w_l0, w_l1} = crbar2(x1, x2, s[2]);
  assign {w_l2, w_l3} = crbar2(x3, x4, s[2]);

  // Column 2
  assign {w_m0, w_m1} = crbar2(w_c2_a0, w_c2_a2, w_c2_sel);
  assign {w_m2, w_m3} = crbar2(w_c2_a1, w_c2_a3, w_c2_sel);

  // Column 3
  assign {w_y1, w_y2} = crbar2(w_c3_a0, w_c3_a2, w_c3_sel);
  assign {w_y3, w_y4} = crbar2(w_c3_a1, w_c3_a3, w_c3_sel);

`ifdef BENES4_PIPE_EN
  logic [N-1:0] r_l0, r_l1, r_l2, r_l3;
  logic [1:0]   r_sel_c1;  // s[1:0] still to be applied
  logic         r_v_c1;
  logic [N-1:0] r_m0, r_m1, r_m2, r_m3;
  logic         r_sel_c2;  // s[0] still to be applied
  logic         r_v_c2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l0     <= '0;
      r_l1     <= '0;
      r_l2     <= '0;
      r_l3     <= '0;
      r_sel_c1 <= '0;
      r_v_c1   <= 1'b0;
      r_m0     <= '0;
      r_m1     <= '0;
      r_m2     <= '0;
      r_m3     <= '0;
      r_sel_c2 <= 1'b0;
      r_v_c2   <= 1'b0;
    end else begin
      r_l0     <= w_l0;
      r_l1     <= w_l1;
      r_l2     <= w_l2;
      r_l3     <= w_l3;
      r_sel_c1 <= s[1:0];
      r_v_c1   <= in_valid;
      r_m0     <= w_m0;
      r_m1     <= w_m1;
      r_m2     <= w_m2;
      r_m3     <= w_m3;
      r_sel_c2 <= r_sel_c1[0];
      r_v_c2   <= r_v_c1;
    end
  end

  assign w_c2_a0       = r_l0;
  assign w_c2_a1       = r_l1;
  assign w_c2_a2       = r_l2;
  assign w_c2_a3       = r_l3;
  assign w_c2_sel      = r_sel_c1[1];
  assign w_c3_a0       = r_m0;
  assign w_c3_a1       = r_m1;
  assign w_c3_a2       = r_m2;
  assign w_c3_a3       = r_m3;
  assign w_c3_sel      = r_sel_c2;
  assign w_out_valid_d = r_v_c2;
`else
  assign w_c2_a0       = w_l0;
  assign w_c2_a1       = w_l1;
  assign w_c2_a2       = w_l2;
  assign w_c2_a3       = w_l3;
  assign w_c2_sel      = s[1];
  assign w_c3_a0       = w_m0;
  assign w_c3_a1       = w_m1;
  assign w_c3_a2       = w_m2;
  assign w_c3_a3       = w_m3;
  assign w_c3_sel      = s[0];
  assign w_out_valid_d = in_valid;
`endif

  // Output register; data is routed even when the slot is not valid.
  logic [N-1:0] r_y1, r_y2, r_y3, r_y4;
  logic         r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y1        <= '0;
      r_y2        <= '0;
      r_y3        <= '0;
      r_y4        <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_y1        <= w_y1;
      r_y2        <= w_y2;
      r_y3        <= w_y3;
      r_y4        <= w_y4;
      r_out_valid <= w_out_valid_d;
    end
  end

  assign y1        = r_y1;
  assign y2        = r_y2;
  assign y3        = r_y3;
  assign y4        = r_y4;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_benes4_crossbar.sv
// Scoreboard bench for benes4_crossbar (N=32). Stimulus pushes the expected
// routed set for every valid input; a monitor pops and compares whenever
// out_valid is high. Expected lane orders are a hand-computed table.
module tb_benes4_crossbar;

`ifdef BENES4_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam logic [31:0] A = 32'h00000000;
  localparam logic [31:0] B = 32'h00080000;
  localparam logic [31:0] C = 32'h00100000;
  localparam logic [31:0] D = 32'h00180000;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] x1, x2, x3, x4;
  logic [2:0]  s;
  logic        out_valid;
  logic [31:0] y1, y2, y3, y4;

  benes4_crossbar #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .x4        (x4),
    .s         (s),
    .out_valid (out_valid),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       code;
    logic [3:0][31:0] x;  // x[0] = x1
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic  ov_log [0:4095];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Source lane order for y1..y4, two bits per lane, y1 in the top bits.
  function automatic logic [7:0] perm_of(input logic [2:0] code);
    case (code)
      3'd0, 3'd5: return 8'h1B;  // A B C D
      3'd1, 3'd4: return 8'h4E;  // B A D C
      3'd2, 3'd7: return 8'hB1;  // C D A B
      default:    return 8'hE4;  // D C B A
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    ov_log[cyc] = out_valid;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        item_t            it;
        logic [7:0]       ord;
        logic [3:0][31:0] ys;
        it    = exp_q.pop_front();
        ord   = perm_of(it.code);
        ys[0] = y1;
        ys[1] = y2;
        ys[2] = y3;
        ys[3] = y4;
        for (int l = 0; l < 4; l++) begin
          logic [1:0] src;
          src = ord[(3-l)*2 +: 2];
          chk($sformatf("lane_y%0d_code%0d", l + 1, it.code), ys[l], it.x[src]);
        end
        for (int i = 0; i < 4; i++) begin
          int n;
          n = 0;
          for (int l = 0; l < 4; l++) if (ys[l] === it.x[i]) n++;
          chk($sformatf("perm_count_x%0d_code%0d", i + 1, it.code), n, 1);
        end
      end
    end
  end

  task automatic send(input logic v, input logic [2:0] code,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    item_t it;
    @(posedge clk);
    #1;
    in_valid = v;
    s        = code;
    x1       = a;
    x2       = b;
    x3       = c;
    x4       = d;
    if (v) begin
      it.code = code;
      it.x    = {d, c, b, a};
      exp_q.push_back(it);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_y1"}, y1, 32'd0);
    chk({tag, "_y2"}, y2, 32'd0);
    chk({tag, "_y3"}, y3, 32'd0);
    chk({tag, "_y4"}, y4, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [2:0] codes [6];
    codes = '{3'b000, 3'b110, 3'b100, 3'b001, 3'b010, 3'b111};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    s        = 3'd0;
    x1       = 32'd0;
    x2       = 32'd0;
    x3       = 32'd0;
    x4       = 32'd0;

    #2;
    chk_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held_out_valid", {31'd0, out_valid}, 32'd0);
    #3;
    rst_n = 1'b1;

    // Single sets from the directed list
    for (int i = 0; i < 6; i++) begin
      send(1'b1, codes[i], A, B, C, D);
      idle(LAT + 1);
    end

    // All eight codes back to back
    for (int c = 0; c < 8; c++) begin
      send(1'b1, 3'(c), A, B, C, D);
      if (c == 0) k = cyc;
    end
    idle(LAT + 2);
    for (int i = 0; i < 8; i++)
      chk($sformatf("burst_out_valid_%0d", i), {31'd0, ov_log[k + LAT + i]}, 32'd1);
    chk("burst_out_valid_end", {31'd0, ov_log[k + LAT + 8]}, 32'd0);

    // Distinct-data sets so every bit position is exercised
    send(1'b1, 3'b011, 32'hDEADBEEF, 32'h01234567, 32'hFFFF0000, 32'h5A5AA5A5);
    send(1'b1, 3'b101, 32'h80000001, 32'h7FFFFFFE, 32'h0F0F0F0F, 32'hC3C3C3C3);
    send(1'b1, 3'b110, 32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888);
    idle(LAT + 2);

    // in_valid 1,0,1
    send(1'b1, 3'b010, A, B, C, D);
    k = cyc;
    send(1'b0, 3'b101, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD);
    send(1'b1, 3'b011, A, B, C, D);
    idle(LAT + 2);
    chk("gap_out_valid_0", {31'd0, ov_log[k + LAT]}, 32'd1);
    chk("gap_out_valid_1", {31'd0, ov_log[k + LAT + 1]}, 32'd0);
    chk("gap_out_valid_2", {31'd0, ov_log[k + LAT + 2]}, 32'd1);

    // Asynchronous reset mid-stream
    send(1'b1, 3'b001, A, B, C, D);
    send(1'b1, 3'b010, A, B, C, D);
    send(1'b1, 3'b011, A, B, C, D);
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    chk_zero_outputs("midreset");
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_reset_idle_%0d", i), {31'd0, out_valid}, 32'd0);
    end
    send(1'b1, 3'b110, A, B, C, D);
    idle(LAT + 2);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
